// File: rtl/psola_window_sequencer.sv
// Packs the sample stream into windows for the PSOLA datapath and launches each one with its pitch period.
// Latency: a sample write appears 1 cycle after acceptance; new_signal_out rises 1 cycle after the launch condition.
// Backpressure: none on the inputs; samples that arrive while the window is full are dropped and counted.
module psola_window_sequencer #(
    parameter int WINDOW_SIZE    = 2048,
    parameter int PERIOD_W       = 12,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int ADDR_W        = $clog2(WINDOW_SIZE),
    localparam int BCNT_W        = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [31:0]         sample_in,
    input  logic                sample_valid_in,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic                period_valid_in,
    input  logic                psola_done_in,
    output logic [31:0]         win_val_out,
    output logic [ADDR_W-1:0]   win_addr_out,
    output logic                win_valid_out,
    output logic                new_signal_out,
    output logic [PERIOD_W-1:0] period_out,
    output logic                busy_out,
    output logic                overrun_out,
    output logic                timeout_out,
    output logic [15:0]         drop_count_out,
    output logic [15:0]         win_count_out
);

    // Per-window progress: FILL while collecting samples, WAIT once the
    // window is full, LAUNCH for the single cycle new_signal_out is high.
    typedef enum logic [1:0] {
        WIN_FILL   = 2'd0,
        WIN_WAIT   = 2'd1,
        WIN_LAUNCH = 2'd2
    } win_state_t;

    // Datapath occupancy: RUN from launch until done edge or timeout.
    typedef enum logic {
        BUSY_IDLE = 1'b0,
        BUSY_RUN  = 1'b1
    } busy_state_t;

    win_state_t          r_win_st;
    busy_state_t         r_busy_st;
    logic [ADDR_W-1:0]   r_fill_cnt;
    logic [PERIOD_W-1:0] r_per_q;
    logic                r_per_rdy;
    logic                r_done_q;
    logic [BCNT_W-1:0]   r_busy_cnt;

    logic                w_full;
    logic                w_launch;
    logic                w_accept;
    logic                w_drop;
    logic                w_last;
    logic                w_done_rise;
    logic [BCNT_W-1:0]   w_busy_cnt_nxt;
    logic                w_timeout_hit;

    // The window is full exactly while it sits in WAIT.
    assign w_full         = (r_win_st == WIN_WAIT);
    // Launch needs a full window, a pending period and an idle datapath;
    // busy is the registered state, so a launch can never share the cycle
    // on which busy clears.
    assign w_launch       = w_full && r_per_rdy && (r_busy_st == BUSY_IDLE);
    // The datapath swaps halves on the launch edge, so no write may land then.
    assign w_accept       = sample_valid_in && !w_full && !w_launch;
    assign w_drop         = sample_valid_in && !w_accept;
    assign w_last         = (r_fill_cnt == ADDR_W'(WINDOW_SIZE - 1));
    // Only a fresh 0->1 transition of done ends a run; a stuck-high level
    // must not retire the next window.
    assign w_done_rise    = psola_done_in && !r_done_q;
    assign w_busy_cnt_nxt = r_busy_cnt + BCNT_W'(1);
    assign w_timeout_hit  = (w_busy_cnt_nxt == BCNT_W'(TIMEOUT_CYCLES));

    // Window FSM: writes accepted samples into the idle half and issues the launch pulse.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_win_st       <= WIN_FILL;
            r_fill_cnt     <= '0;
            win_val_out    <= '0;
            win_addr_out   <= '0;
            win_valid_out  <= 1'b0;
            new_signal_out <= 1'b0;
            period_out     <= '0;
            win_count_out  <= '0;
        end else begin
            win_valid_out  <= w_accept;
            new_signal_out <= w_launch;

            if (w_accept) begin
                win_val_out  <= sample_in;
                win_addr_out <= r_fill_cnt;
                r_fill_cnt   <= w_last ? '0 : r_fill_cnt + ADDR_W'(1);
            end

            case (r_win_st)
                WIN_FILL, WIN_LAUNCH: begin
                    if (w_accept && w_last) begin
                        r_win_st <= WIN_WAIT;
                    end else begin
                        r_win_st <= WIN_FILL;
                    end
                end
                WIN_WAIT: begin
                    if (w_launch) begin
                        r_win_st      <= WIN_LAUNCH;
                        period_out    <= r_per_q;
                        win_count_out <= win_count_out + 16'd1;
                    end
                end
                default: begin
                    r_win_st <= WIN_FILL;
                end
            endcase
        end
    end

    // Period holding register: newest period wins; a period arriving on the
    // launch cycle is kept pending for the following window.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_per_q   <= '0;
            r_per_rdy <= 1'b0;
        end else if (period_valid_in) begin
            r_per_q   <= period_in;
            r_per_rdy <= 1'b1;
        end else if (w_launch) begin
            r_per_rdy <= 1'b0;
        end
    end

    // Busy FSM: tracks the in-flight window and abandons it after the timeout.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_busy_st   <= BUSY_IDLE;
            r_busy_cnt  <= '0;
            r_done_q    <= 1'b0;
            busy_out    <= 1'b0;
            timeout_out <= 1'b0;
        end else begin
            r_done_q <= psola_done_in;
            case (r_busy_st)
                BUSY_IDLE: begin
                    if (w_launch) begin
                        r_busy_st  <= BUSY_RUN;
                        r_busy_cnt <= '0;
                        busy_out   <= 1'b1;
                    end
                end
                BUSY_RUN: begin
                    // A done edge coinciding with the timeout is a normal
                    // completion and must not raise the timeout flag.
                    if (w_done_rise) begin
                        r_busy_st <= BUSY_IDLE;
                        busy_out  <= 1'b0;
                    end else if (w_timeout_hit) begin
                        r_busy_st   <= BUSY_IDLE;
                        busy_out    <= 1'b0;
                        timeout_out <= 1'b1;
                        r_busy_cnt  <= w_busy_cnt_nxt;
                    end else begin
                        r_busy_cnt <= w_busy_cnt_nxt;
                    end
                end
                default: begin
                    r_busy_st <= BUSY_IDLE;
                    busy_out  <= 1'b0;
                end
            endcase
        end
    end

    // Overrun status: sticky flag plus a saturating count of dropped samples.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            overrun_out    <= 1'b0;
            drop_count_out <= '0;
        end else if (w_drop) begin
            overrun_out <= 1'b1;
            if (drop_count_out != 16'hFFFF) begin
                drop_count_out <= drop_count_out + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_psola_window_sequencer.sv
// Directed bench for psola_window_sequencer with 8-sample windows and a 32-cycle timeout.
// Latency: expected values are hand-derived per cycle; outputs are sampled 1 time unit after each rising edge.
// Backpressure: none; the bench drives samples and periods freely and checks drop accounting.
module tb_psola_window_sequencer;

    logic        clk_in;
    logic        rst_n_in;
    logic [31:0] sample_in;
    logic        sample_valid_in;
    logic [11:0] period_in;
    logic        period_valid_in;
    logic        psola_done_in;
    logic [31:0] win_val_out;
    logic [2:0]  win_addr_out;
    logic        win_valid_out;
    logic        new_signal_out;
    logic [11:0] period_out;
    logic        busy_out;
    logic        overrun_out;
    logic        timeout_out;
    logic [15:0] drop_count_out;
    logic [15:0] win_count_out;

    int n_cmp = 0;
    int n_err = 0;

    psola_window_sequencer #(
        .WINDOW_SIZE   (8),
        .PERIOD_W      (12),
        .TIMEOUT_CYCLES(32)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .sample_in      (sample_in),
        .sample_valid_in(sample_valid_in),
        .period_in      (period_in),
        .period_valid_in(period_valid_in),
        .psola_done_in  (psola_done_in),
        .win_val_out    (win_val_out),
        .win_addr_out   (win_addr_out),
        .win_valid_out  (win_valid_out),
        .new_signal_out (new_signal_out),
        .period_out     (period_out),
        .busy_out       (busy_out),
        .overrun_out    (overrun_out),
        .timeout_out    (timeout_out),
        .drop_count_out (drop_count_out),
        .win_count_out  (win_count_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_sample(input logic [31:0] v);
        sample_in       = v;
        sample_valid_in = 1'b1;
        tick();
        sample_valid_in = 1'b0;
    endtask

    task automatic drive_period(input logic [11:0] p);
        period_in       = p;
        period_valid_in = 1'b1;
        tick();
        period_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; sample_in = '0; sample_valid_in = 1'b0;
        period_in = '0; period_valid_in = 1'b0; psola_done_in = 1'b0;
        #1;
        n_cmp++; if (win_val_out !== 32'd0) begin n_err++; $display("FAIL reset_win_val got %0h exp 0", win_val_out); end
        n_cmp++; if (win_addr_out !== 3'd0) begin n_err++; $display("FAIL reset_win_addr got %0d exp 0", win_addr_out); end
        n_cmp++; if (win_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_win_valid got %0b exp 0", win_valid_out); end
        n_cmp++; if (new_signal_out !== 1'b0) begin n_err++; $display("FAIL reset_new_signal got %0b exp 0", new_signal_out); end
        n_cmp++; if (period_out !== 12'd0) begin n_err++; $display("FAIL reset_period got %0d exp 0", period_out); end
        n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b exp 0", busy_out); end
        n_cmp++; if (overrun_out !== 1'b0) begin n_err++; $display("FAIL reset_overrun got %0b exp 0", overrun_out); end
        n_cmp++; if (timeout_out !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %0b exp 0", timeout_out); end
        n_cmp++; if (drop_count_out !== 16'd0) begin n_err++; $display("FAIL reset_drop_count got %0d exp 0", drop_count_out); end
        n_cmp++; if (win_count_out !== 16'd0) begin n_err++; $display("FAIL reset_win_count got %0d exp 0", win_count_out); end
        tick();
        rst_n_in = 1'b1;
        tick();
    endtask

    // Scenario 1: first window launches without waiting for done.
    task automatic test_fill_launch();
        drive_period(12'd100);
        for (int i = 0; i < 8; i++) begin
            drive_sample(32'(i + 1));
            n_cmp++;
            if (win_valid_out !== 1'b1 || win_addr_out !== 3'(i) || win_val_out !== 32'(i + 1)) begin
                n_err++;
                $display("FAIL fill_write%0d got v=%0b a=%0d d=%0d exp v=1 a=%0d d=%0d",
                         i, win_valid_out, win_addr_out, win_val_out, i, i + 1);
            end
        end
        n_cmp++; if (new_signal_out !== 1'b0) begin n_err++; $display("FAIL fill_early_launch got %0b exp 0", new_signal_out); end
        tick();
        n_cmp++; if (new_signal_out !== 1'b1) begin n_err++; $display("FAIL fill_launch got %0b exp 1", new_signal_out); end
        n_cmp++; if (period_out !== 12'd100) begin n_err++; $display("FAIL fill_period got %0d exp 100", period_out); end
        n_cmp++; if (win_count_out !== 16'd1) begin n_err++; $display("FAIL fill_win_count got %0d exp 1", win_count_out); end
        n_cmp++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL fill_busy got %0b exp 1", busy_out); end
        n_cmp++; if (win_valid_out !== 1'b0) begin n_err++; $display("FAIL fill_valid_idle got %0b exp 0", win_valid_out); end
        tick();
        n_cmp++; if (new_signal_out !== 1'b0) begin n_err++; $display("FAIL fill_pulse_width got %0b exp 0", new_signal_out); end
        n_cmp++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL fill_busy_hold got %0b exp 1", busy_out); end
    endtask

    // Scenario 2: second window waits for the done edge, then launches one cycle later.
    task automatic test_back_to_back();
        drive_period(12'd200);
        for (int i = 0; i < 8; i++) begin
            drive_sample(32'(11 + i));
            n_cmp++;
            if (win_valid_out !== 1'b1 || win_addr_out !== 3'(i)) begin
                n_err++;
                $display("FAIL b2b_write%0d got v=%0b a=%0d exp v=1 a=%0d", i, win_valid_out, win_addr_out, i);
            end
        end
        repeat (5) tick();
        n_cmp++; if (new_signal_out !== 1'b0 || win_count_out !== 16'd1) begin n_err++; $display("FAIL b2b_held got ns=%0b wc=%0d exp ns=0 wc=1", new_signal_out, win_count_out); end
        n_cmp++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL b2b_busy_before got %0b exp 1", busy_out); end
        psola_done_in = 1'b1;
        tick();
        n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL b2b_busy_clear got %0b exp 0", busy_out); end
        n_cmp++; if (new_signal_out !== 1'b0) begin n_err++; $display("FAIL b2b_same_cycle_launch got %0b exp 0", new_signal_out); end
        tick();
        n_cmp++; if (new_signal_out !== 1'b1 || busy_out !== 1'b1) begin n_err++; $display("FAIL b2b_launch got ns=%0b busy=%0b exp 1 1", new_signal_out, busy_out); end
        n_cmp++; if (win_count_out !== 16'd2) begin n_err++; $display("FAIL b2b_win_count got %0d exp 2", win_count_out); end
        n_cmp++; if (period_out !== 12'd200) begin n_err++; $display("FAIL b2b_period got %0d exp 200", period_out); end
        n_cmp++; if (drop_count_out !== 16'd0 || overrun_out !== 1'b0) begin n_err++; $display("FAIL b2b_no_drop got dc=%0d ov=%0b exp 0 0", drop_count_out, overrun_out); end
        psola_done_in = 1'b0;
        tick();
        n_cmp++; if (new_signal_out !== 1'b0) begin n_err++; $display("FAIL b2b_pulse_width got %0b exp 0", new_signal_out); end
    endtask

    // Scenario 3: full window without a period drops extra samples and waits.
    task automatic test_drop_no_period();
        psola_done_in = 1'b1;
        tick();
        n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL drop_busy_clear got %0b exp 0", busy_out); end
        psola_done_in = 1'b0;
        for (int i = 0; i < 8; i++) drive_sample(32'(21 + i));
        for (int k = 0; k < 3; k++) begin
            drive_sample(32'(29 + k));
            n_cmp++; if (win_valid_out !== 1'b0) begin n_err++; $display("FAIL drop_write%0d got %0b exp 0", k, win_valid_out); end
        end
        n_cmp++; if (drop_count_out !== 16'd3) begin n_err++; $display("FAIL drop_count got %0d exp 3", drop_count_out); end
        n_cmp++; if (overrun_out !== 1'b1) begin n_err++; $display("FAIL drop_overrun got %0b exp 1", overrun_out); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (new_signal_out !== 1'b0) begin n_err++; $display("FAIL drop_no_launch%0d got %0b exp 0", k, new_signal_out); end
        end
        drive_period(12'd300);
        n_cmp++; if (new_signal_out !== 1'b0) begin n_err++; $display("FAIL drop_period_cycle got %0b exp 0", new_signal_out); end
        tick();
        n_cmp++; if (new_signal_out !== 1'b1 || period_out !== 12'd300) begin n_err++; $display("FAIL drop_launch got ns=%0b p=%0d exp 1 300", new_signal_out, period_out); end
        n_cmp++; if (win_count_out !== 16'd3) begin n_err++; $display("FAIL drop_win_count got %0d exp 3", win_count_out); end
    endtask

    // Scenario 4: done stuck high gives no edge, so the window times out.
    task automatic test_timeout();
        psola_done_in = 1'b1;
        tick();
        n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL to_busy_clear got %0b exp 0", busy_out); end
        drive_period(12'd400);
        for (int i = 0; i < 8; i++) drive_sample(32'(41 + i));
        tick();
        n_cmp++; if (new_signal_out !== 1'b1 || win_count_out !== 16'd4 || busy_out !== 1'b1) begin n_err++; $display("FAIL to_launch got ns=%0b wc=%0d busy=%0b exp 1 4 1", new_signal_out, win_count_out, busy_out); end
        for (int i = 1; i <= 31; i++) begin
            period_valid_in = (i == 1);
            period_in       = 12'd500;
            sample_valid_in = (i >= 2 && i <= 9);
            sample_in       = 32'(50 + i);
            tick();
            n_cmp++; if (busy_out !== 1'b1 || timeout_out !== 1'b0) begin n_err++; $display("FAIL to_run%0d got busy=%0b to=%0b exp 1 0", i, busy_out, timeout_out); end
        end
        period_valid_in = 1'b0;
        sample_valid_in = 1'b0;
        tick();
        n_cmp++; if (busy_out !== 1'b0 || timeout_out !== 1'b1) begin n_err++; $display("FAIL to_expire got busy=%0b to=%0b exp 0 1", busy_out, timeout_out); end
        n_cmp++; if (new_signal_out !== 1'b0) begin n_err++; $display("FAIL to_same_cycle_launch got %0b exp 0", new_signal_out); end
        tick();
        n_cmp++; if (new_signal_out !== 1'b1 || period_out !== 12'd500 || win_count_out !== 16'd5) begin n_err++; $display("FAIL to_next_launch got ns=%0b p=%0d wc=%0d exp 1 500 5", new_signal_out, period_out, win_count_out); end
        n_cmp++; if (drop_count_out !== 16'd3) begin n_err++; $display("FAIL to_drop_count got %0d exp 3", drop_count_out); end
    endtask

    // Scenario 5: sample and period on the launch cycle.
    task automatic test_launch_collision();
        psola_done_in = 1'b0;
        tick();
        psola_done_in = 1'b1;
        tick();
        n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL col_busy_clear got %0b exp 0", busy_out); end
        drive_period(12'd600);
        for (int i = 0; i < 8; i++) drive_sample(32'(51 + i));
        sample_in = 32'd99; sample_valid_in = 1'b1;
        period_in = 12'd700; period_valid_in = 1'b1;
        tick();
        sample_valid_in = 1'b0; period_valid_in = 1'b0;
        n_cmp++; if (new_signal_out !== 1'b1 || period_out !== 12'd600) begin n_err++; $display("FAIL col_launch got ns=%0b p=%0d exp 1 600", new_signal_out, period_out); end
        n_cmp++; if (win_valid_out !== 1'b0) begin n_err++; $display("FAIL col_no_write got %0b exp 0", win_valid_out); end
        n_cmp++; if (drop_count_out !== 16'd4 || win_count_out !== 16'd6) begin n_err++; $display("FAIL col_counts got dc=%0d wc=%0d exp 4 6", drop_count_out, win_count_out); end
        psola_done_in = 1'b0;
        tick();
        psola_done_in = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            drive_sample(32'(61 + i));
            if (i == 0) begin
                n_cmp++; if (win_addr_out !== 3'd0 || win_val_out !== 32'd61) begin n_err++; $display("FAIL col_next_first got a=%0d d=%0d exp 0 61", win_addr_out, win_val_out); end
            end
        end
        tick();
        n_cmp++; if (new_signal_out !== 1'b1 || period_out !== 12'd700 || win_count_out !== 16'd7) begin n_err++; $display("FAIL col_kept_period got ns=%0b p=%0d wc=%0d exp 1 700 7", new_signal_out, period_out, win_count_out); end
    endtask

    // Scenario 6: asynchronous reset in the middle of a fill.
    task automatic test_reset_mid_fill();
        psola_done_in = 1'b0;
        for (int i = 0; i < 5; i++) drive_sample(32'(71 + i));
        n_cmp++; if (win_addr_out !== 3'd4 || win_val_out !== 32'd75) begin n_err++; $display("FAIL rst_pre_addr got a=%0d d=%0d exp 4 75", win_addr_out, win_val_out); end
        #2;
        rst_n_in = 1'b0;
        #1;
        n_cmp++; if (win_valid_out !== 1'b0 || win_addr_out !== 3'd0 || win_val_out !== 32'd0) begin n_err++; $display("FAIL rst_mid_write got v=%0b a=%0d d=%0d exp 0 0 0", win_valid_out, win_addr_out, win_val_out); end
        n_cmp++; if (busy_out !== 1'b0 || new_signal_out !== 1'b0 || period_out !== 12'd0) begin n_err++; $display("FAIL rst_mid_ctrl got busy=%0b ns=%0b p=%0d exp 0 0 0", busy_out, new_signal_out, period_out); end
        n_cmp++; if (overrun_out !== 1'b0 || timeout_out !== 1'b0) begin n_err++; $display("FAIL rst_mid_flags got ov=%0b to=%0b exp 0 0", overrun_out, timeout_out); end
        n_cmp++; if (drop_count_out !== 16'd0 || win_count_out !== 16'd0) begin n_err++; $display("FAIL rst_mid_counts got dc=%0d wc=%0d exp 0 0", drop_count_out, win_count_out); end
        tick();
        rst_n_in = 1'b1;
        tick();
        drive_sample(32'd77);
        n_cmp++; if (win_valid_out !== 1'b1 || win_addr_out !== 3'd0 || win_val_out !== 32'd77) begin n_err++; $display("FAIL rst_restart got v=%0b a=%0d d=%0d exp 1 0 77", win_valid_out, win_addr_out, win_val_out); end
    endtask

    initial begin
        test_reset();
        test_fill_launch();
        test_back_to_back();
        test_drop_no_period();
        test_timeout();
        test_launch_collision();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete, compared=%0d", n_cmp);
        $fatal(1);
    end

endmodule
